// File: rtl/fun_fpsu_lanes_merge_pkg.sv
// Shared types and defaults for the FP SIMD lane-merge retire block.
// The entry record holds the lane mask, per-lane completion flags and merged retire code.
package fun_fpsu_lanes_merge_pkg;

    localparam int RET_W     = 14;
    localparam int NPORT_DEF = 6;
    localparam int NLANE_DEF = 2;
    localparam int DEPTH_DEF = 4;
    localparam int LANE_MAX  = 8;

    // Lane fields are sized for the widest supported slicing; bits above NLANE stay zero.
    typedef struct packed {
        logic [LANE_MAX-1:0] mask;
        logic [LANE_MAX-1:0] done;
        logic [RET_W-1:0]    acc;
    } entry_t;

endpackage

// File: rtl/fun_fpsu_lanes_merge_if.sv
// Issue / lane-return / merged-retire bundle for all ports of the lane-merge block.
// The master side issues ops and returns lane codes; the slave side is the merge block.
interface fun_fpsu_lanes_merge_if
    import fun_fpsu_lanes_merge_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int NLANE = NLANE_DEF
);

    logic                           flush;
    logic [NPORT-1:0]               iss_vld;
    logic [NPORT*NLANE-1:0]         iss_mask;
    logic [NPORT-1:0]               iss_rdy;
    logic [NPORT*NLANE*RET_W-1:0]   lane_ret;
    logic [NPORT*NLANE-1:0]         lane_ret_en;
    logic [NPORT*RET_W-1:0]         ret;
    logic [NPORT-1:0]               ret_en;
    logic [NPORT-1:0]               err;

    modport master (
        output flush, iss_vld, iss_mask, lane_ret, lane_ret_en,
        input  iss_rdy, ret, ret_en, err
    );

    modport slave (
        input  flush, iss_vld, iss_mask, lane_ret, lane_ret_en,
        output iss_rdy, ret, ret_en, err
    );

endinterface

// File: rtl/fun_fpsu_lanes_merge_ret_trk.sv
// Single-port in-order tracker: queues issued ops, collects per-lane returns,
// OR-merges enabled lane codes and emits one registered retire per op.
module fun_fpsu_lanes_merge_ret_trk
    import fun_fpsu_lanes_merge_pkg::*;
#(
    parameter int NLANE = NLANE_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        iss_vld,
    input  logic [NLANE-1:0]            iss_mask,
    output logic                        iss_rdy,
    input  logic [NLANE-1:0][RET_W-1:0] lane_ret,
    input  logic [NLANE-1:0]            lane_ret_en,
    output logic [RET_W-1:0]            ret,
    output logic                        ret_en,
    output logic                        err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

    // Write and lane pointers carry one extra wrap bit so "lane has nothing pending"
    // is simply lane_ptr == wr_ptr, even when the queue is full.
    typedef logic [PW:0] ptr_t;

    entry_t           entries     [DEPTH];
    entry_t           entries_nxt [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             lane_ptr    [NLANE];
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    logic [NLANE-1:0]    hit;
    logic [NLANE-1:0]    miss;
    logic [LANE_MAX-1:0] mask_ext;
    entry_t              head;
    logic                retire;
    logic                issue;

    assign iss_rdy = (count != CNT_FULL);
    assign issue   = iss_vld && iss_rdy;

    always_comb begin
        // NOTE: every comb output gets a full default first, so no path leaves a latch.
        entries_nxt = entries;
        hit         = '0;
        miss        = '0;
        mask_ext    = '0;
        mask_ext[NLANE-1:0] = iss_mask;

        for (int l = 0; l < NLANE; l++) begin
            hit[l]  = lane_ret_en[l] && (lane_ptr[l] != wr_ptr);
            miss[l] = lane_ret_en[l] && (lane_ptr[l] == wr_ptr);
            if (hit[l]) begin
                entries_nxt[lane_ptr[l][PW-1:0]].done[l] = 1'b1;
                if (entries[lane_ptr[l][PW-1:0]].mask[l])
                    entries_nxt[lane_ptr[l][PW-1:0]].acc =
                        entries_nxt[lane_ptr[l][PW-1:0]].acc | lane_ret[l];
            end
        end

        // Head is judged after this cycle's returns fold in: last return at N retires at N+1.
        head   = entries_nxt[rd_ptr];
        retire = (count != '0) && (&head.done[NLANE-1:0]);

        // A non-full queue never has its write slot live, so this cannot clobber the head.
        if (issue)
            entries_nxt[wr_ptr[PW-1:0]] = '{mask: mask_ext, done: '0, acc: '0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the entry array is reset too, so state after reset is fully defined.
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            for (int l = 0; l < NLANE; l++) lane_ptr[l] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            ret    <= '0;
            ret_en <= 1'b0;
        end else if (flush) begin
            for (int l = 0; l < NLANE; l++) lane_ptr[l] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            ret    <= '0;
            ret_en <= 1'b0;
        end else begin
            entries <= entries_nxt;
            for (int l = 0; l < NLANE; l++)
                if (hit[l]) lane_ptr[l] <= lane_ptr[l] + 1'b1;
            if (issue)  wr_ptr <= wr_ptr + 1'b1;
            if (retire) rd_ptr <= rd_ptr + 1'b1;
            unique case ({issue, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (|miss) err <= 1'b1;
            ret_en <= retire;
            ret    <= retire ? head.acc : '0;
        end
    end

endmodule

// File: rtl/fun_fpsu_lanes_merge.sv
// Lane-merge retire block: one independent tracker per issue port;
// this level only slices the flattened buses.
module fun_fpsu_lanes_merge
    import fun_fpsu_lanes_merge_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int NLANE = NLANE_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    fun_fpsu_lanes_merge_if.slave bus
);

    logic [NPORT-1:0]            rdy_p;
    logic [NPORT-1:0]            ret_en_p;
    logic [NPORT-1:0]            err_p;
    logic [NPORT-1:0][RET_W-1:0] ret_p;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        fun_fpsu_lanes_merge_ret_trk #(
            .NLANE (NLANE),
            .DEPTH (DEPTH)
        ) u_trk (
            .clk         (clk),
            .rst         (rst),
            .flush       (bus.flush),
            .iss_vld     (bus.iss_vld[p]),
            .iss_mask    (bus.iss_mask[p*NLANE +: NLANE]),
            .iss_rdy     (rdy_p[p]),
            .lane_ret    (bus.lane_ret[p*NLANE*RET_W +: NLANE*RET_W]),
            .lane_ret_en (bus.lane_ret_en[p*NLANE +: NLANE]),
            .ret         (ret_p[p]),
            .ret_en      (ret_en_p[p]),
            .err         (err_p[p])
        );
    end

    assign bus.iss_rdy = rdy_p;
    assign bus.ret     = ret_p;
    assign bus.ret_en  = ret_en_p;
    assign bus.err     = err_p;

endmodule

// File: tb/tb_fun_fpsu_lanes_merge.sv
// Directed bench for fun_fpsu_lanes_merge: a table of single-op merges across ports
// plus hand-written sequences for fill, out-of-step lanes, errors, flush and async reset.
module tb_fun_fpsu_lanes_merge;
    import fun_fpsu_lanes_merge_pkg::*;

    localparam int NPORT = 6;
    localparam int NLANE = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    fun_fpsu_lanes_merge_if #(.NPORT(NPORT), .NLANE(NLANE)) bus ();

    fun_fpsu_lanes_merge #(.NPORT(NPORT), .NLANE(NLANE), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         port;
        logic [1:0] mask;
        logic [13:0] c0;
        logic [13:0] c1;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        bus.iss_vld     = '0;
        bus.lane_ret_en = '0;
        bus.lane_ret    = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic set_iss(input int p, input logic [1:0] m);
        bus.iss_vld[p] = 1'b1;
        bus.iss_mask[p*NLANE +: NLANE] = m;
    endtask

    task automatic set_ret(input int p, input int l, input logic [13:0] c);
        bus.lane_ret_en[p*NLANE+l] = 1'b1;
        bus.lane_ret[(p*NLANE+l)*RET_W +: RET_W] = c;
    endtask

    function automatic logic [13:0] ret_of(input int p);
        return bus.ret[p*RET_W +: RET_W];
    endfunction

    function automatic logic [13:0] code0(input int k);
        return 14'd1 << k;
    endfunction

    function automatic logic [13:0] code1(input int k);
        return 14'd1 << (k + 7);
    endfunction

    logic [5:0] sel;

    initial begin
        vecs[0] = '{port: 0, mask: 2'b11, c0: 14'h0004, c1: 14'h0100, exp: 14'h0104};
        vecs[1] = '{port: 1, mask: 2'b01, c0: 14'h0001, c1: 14'h3FFF, exp: 14'h0001};
        vecs[2] = '{port: 2, mask: 2'b10, c0: 14'h0F00, c1: 14'h00F0, exp: 14'h00F0};
        vecs[3] = '{port: 3, mask: 2'b00, c0: 14'h3FFF, c1: 14'h3FFF, exp: 14'h0000};
        vecs[4] = '{port: 4, mask: 2'b11, c0: 14'h2AAA, c1: 14'h1555, exp: 14'h3FFF};
        vecs[5] = '{port: 5, mask: 2'b10, c0: 14'h0001, c1: 14'h2000, exp: 14'h2000};

        rst             = 1'b0;
        bus.flush       = 1'b0;
        bus.iss_vld     = '0;
        bus.iss_mask    = '0;
        bus.lane_ret    = '0;
        bus.lane_ret_en = '0;
        #1;
        check("rst_iss_rdy", 32'(bus.iss_rdy), 32'h3F);
        check("rst_ret_en",  32'(bus.ret_en),  32'h0);
        check("rst_err",     32'(bus.err),     32'h0);
        check("rst_ret",     32'(bus.ret == '0), 32'h1);
        cyc();
        rst = 1'b1;
        cyc();

        // Table: one op per vector, both lanes return together one cycle after issue.
        for (int i = 0; i < 6; i++) begin
            sel = 6'b000001 << vecs[i].port;
            set_iss(vecs[i].port, vecs[i].mask);
            cyc();
            set_ret(vecs[i].port, 0, vecs[i].c0);
            set_ret(vecs[i].port, 1, vecs[i].c1);
            cyc();
            check($sformatf("vec%0d_ret_en", i), 32'(bus.ret_en), 32'(sel));
            check($sformatf("vec%0d_ret", i), 32'(ret_of(vecs[i].port)), 32'(vecs[i].exp));
            cyc();
            check($sformatf("vec%0d_idle", i), 32'(bus.ret_en), 32'h0);
        end

        // Lanes return on different cycles: retire one cycle after the last one.
        set_iss(0, 2'b11);
        cyc();
        cyc();
        set_ret(0, 0, 14'h0004);
        cyc();
        check("split_wait", 32'(bus.ret_en[0]), 32'h0);
        cyc();
        set_ret(0, 1, 14'h0100);
        cyc();
        check("split_ret_en", 32'(bus.ret_en[0]), 32'h1);
        check("split_ret", 32'(ret_of(0)), 32'h0104);
        cyc();

        // Fill port 0, ignored fifth issue, retire frees a slot, issue+retire keeps count.
        for (int k = 0; k < 4; k++) begin
            set_iss(0, 2'b11);
            cyc();
        end
        check("full_rdy", 32'(bus.iss_rdy[0]), 32'h0);
        set_iss(0, 2'b11);
        cyc();
        check("full_ignored_rdy", 32'(bus.iss_rdy[0]), 32'h0);
        check("full_ignored_err", 32'(bus.err[0]), 32'h0);
        set_ret(0, 0, code0(0));
        set_ret(0, 1, code1(0));
        cyc();
        check("fill_retA", 32'(ret_of(0)), 32'(code0(0) | code1(0)));
        check("fill_rdy_back", 32'(bus.iss_rdy[0]), 32'h1);
        set_iss(0, 2'b11);
        set_ret(0, 0, code0(1));
        set_ret(0, 1, code1(1));
        cyc();
        check("isret_retB", 32'(ret_of(0)), 32'(code0(1) | code1(1)));
        check("isret_rdy", 32'(bus.iss_rdy[0]), 32'h1);
        set_iss(0, 2'b11);
        cyc();
        check("isret_count3", 32'(bus.iss_rdy[0]), 32'h0);
        for (int k = 2; k < 6; k++) begin
            set_ret(0, 0, code0(k));
            set_ret(0, 1, code1(k));
            cyc();
            check($sformatf("drain%0d_en", k), 32'(bus.ret_en[0]), 32'h1);
            check($sformatf("drain%0d_ret", k), 32'(ret_of(0)), 32'(code0(k) | code1(k)));
        end
        check("drain_rdy", 32'(bus.iss_rdy[0]), 32'h1);
        set_ret(0, 0, 14'h0001);
        cyc();
        check("drain_extra_err", 32'(bus.err[0]), 32'h1);

        // Out-of-step lanes on port 1: lane1 runs ahead of lane0.
        set_iss(1, 2'b11);
        cyc();
        set_iss(1, 2'b10);
        cyc();
        set_ret(1, 1, 14'h0200);
        cyc();
        set_ret(1, 1, 14'h0020);
        cyc();
        check("ooo_wait", 32'(bus.ret_en[1]), 32'h0);
        set_ret(1, 0, 14'h0003);
        cyc();
        check("ooo_A_en", 32'(bus.ret_en[1]), 32'h1);
        check("ooo_A_ret", 32'(ret_of(1)), 32'h0203);
        set_ret(1, 0, 14'h1000);
        cyc();
        check("ooo_B_en", 32'(bus.ret_en[1]), 32'h1);
        check("ooo_B_ret", 32'(ret_of(1)), 32'h0020);
        cyc();
        check("ooo_done", 32'(bus.ret_en[1]), 32'h0);
        check("ooo_ret_zero", 32'(ret_of(1)), 32'h0);

        // Return on empty port 2 is sticky; flush clears it and drops in-flight work.
        set_ret(2, 0, 14'h0055);
        cyc();
        check("err2_set", 32'(bus.err), 32'h05);
        cyc();
        cyc();
        check("err2_sticky", 32'(bus.err[2]), 32'h1);
        set_iss(3, 2'b11);
        cyc();
        set_ret(3, 0, 14'h0011);
        cyc();
        bus.flush = 1'b1;
        set_ret(3, 1, 14'h2200);
        set_iss(1, 2'b01);
        cyc();
        check("flush_ret_en", 32'(bus.ret_en), 32'h0);
        check("flush_err", 32'(bus.err), 32'h0);
        check("flush_rdy", 32'(bus.iss_rdy), 32'h3F);
        cyc();
        check("flush_quiet", 32'(bus.ret_en), 32'h0);
        set_iss(3, 2'b11);
        cyc();
        set_ret(3, 0, 14'h0011);
        set_ret(3, 1, 14'h2200);
        cyc();
        check("post_flush_ret", 32'(ret_of(3)), 32'h2211);
        check("post_flush_err", 32'(bus.err), 32'h0);

        // Async reset with three ops outstanding and a retire pulse on the outputs.
        for (int k = 0; k < 4; k++) begin
            set_iss(4, 2'b11);
            cyc();
        end
        set_ret(5, 1, 14'h0001);
        set_ret(4, 0, 14'h0041);
        set_ret(4, 1, 14'h0082);
        cyc();
        check("pre_rst_ret", 32'(ret_of(4)), 32'h00C3);
        check("pre_rst_err", 32'(bus.err), 32'h20);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ret_en", 32'(bus.ret_en), 32'h0);
        check("arst_ret", 32'(bus.ret == '0), 32'h1);
        check("arst_err", 32'(bus.err), 32'h0);
        check("arst_rdy", 32'(bus.iss_rdy), 32'h3F);
        cyc();
        rst = 1'b1;
        cyc();
        set_iss(4, 2'b10);
        cyc();
        set_ret(4, 0, 14'h0005);
        set_ret(4, 1, 14'h0300);
        cyc();
        check("after_rst_en", 32'(bus.ret_en), 32'h10);
        check("after_rst_ret", 32'(ret_of(4)), 32'h0300);
        check("after_rst_err", 32'(bus.err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
